lav_scheduler: RTL and testbench

LAV_SCHEDULER -- requirements
Module: lav_scheduler

---
 rtl/lav_pkg.sv | 37 +++
 rtl/lav_scheduler_if.sv | 22 ++
 rtl/lav_machine.sv | 72 +++++++
 rtl/lav_scheduler.sv | 98 +++++++++
 tb/tb_lav_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lav_pkg.sv
// Shared program encodings, default run lengths and the program-to-duration helper.
// Optional build macro: LAV_SCHED_CANCEL_EN (per-machine abort input).
package lav_pkg;

  typedef enum logic [1:0] {
    PROG_NONE = 2'b00,
    PROG_SEC  = 2'b01,
    PROG_LAV  = 2'b10,
    PROG_PES  = 2'b11
  } prog_e;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_RUN  = 1'b1
  } mstate_e;

  localparam int unsigned T_SEC_DEF = 3;
  localparam int unsigned T_LAV_DEF = 4;
  localparam int unsigned T_PES_DEF = 9;

  function automatic logic [3:0] prog_len(
    input logic [1:0]  p,
    input int unsigned ts,
    input int unsigned tl,
    input int unsigned tp
  );
    logic [3:0] len;
    unique case (p)
      PROG_SEC: len = 4'(ts);
      PROG_LAV: len = 4'(tl);
      PROG_PES: len = 4'(tp);
      default:  len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/lav_scheduler_if.sv
// Job request handshake between a requester and the scheduler.
// Optional build macro: LAV_SCHED_CANCEL_EN (not used here).
interface lav_scheduler_if;
  logic       req_valid;
  logic [1:0] req_prog;
  logic       req_ready;
  logic       reject;

  modport master (
    output req_valid,
    output req_prog,
    input  req_ready,
    input  reject
  );

  modport slave (
    input  req_valid,
    input  req_prog,
    output req_ready,
    output reject
  );
endinterface

// File: rtl/lav_machine.sv
// One wash machine: IDLE/RUN FSM with a down-counting run timer.
// Optional build macro: LAV_SCHED_CANCEL_EN adds the cancel input.
module lav_machine
  import lav_pkg::*;
#(
  parameter int unsigned T_SEC = T_SEC_DEF,
  parameter int unsigned T_LAV = T_LAV_DEF,
  parameter int unsigned T_PES = T_PES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] start_prog,
`ifdef LAV_SCHED_CANCEL_EN
  input  logic       cancel,
`endif
  output logic       busy,
  output logic [1:0] prog,
  output logic       done
);

  mstate_e    state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [1:0] prog_q,  prog_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= M_IDLE;
      timer_q <= 4'd0;
      prog_q  <= PROG_NONE;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prog_q  <= prog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    prog_d  = prog_q;
    done    = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (start) begin
          state_d = M_RUN;
          timer_d = prog_len(start_prog, T_SEC, T_LAV, T_PES) - 4'd1;
          prog_d  = start_prog;
        end
      end
      M_RUN: begin
        // completion takes priority over an abort in the same cycle
        if (timer_q == 4'd0) begin
          done    = 1'b1;
          state_d = M_IDLE;
          prog_d  = PROG_NONE;
`ifdef LAV_SCHED_CANCEL_EN
        end else if (cancel) begin
          state_d = M_IDLE;
          prog_d  = PROG_NONE;
`endif
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
    endcase
  end

  assign busy = (state_q == M_RUN);
  assign prog = prog_q;

endmodule

// File: rtl/lav_scheduler.sv
// Job FIFO, lowest-index dispatch arbiter and reject logic for two machines.
// Optional build macro: LAV_SCHED_CANCEL_EN exposes the cancel[1:0] port.
module lav_scheduler
  import lav_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned T_SEC  = T_SEC_DEF,
  parameter int unsigned T_LAV  = T_LAV_DEF,
  parameter int unsigned T_PES  = T_PES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  lav_scheduler_if.slave        req,
`ifdef LAV_SCHED_CANCEL_EN
  input  logic [1:0]            cancel,
`endif
  output logic [1:0]            m_busy,
  output logic [3:0]            m_prog,
  output logic [1:0]            m_done,
  output logic [3:0]            q_count
);

  localparam int unsigned AW = $clog2(QDEPTH);

  logic [1:0]    mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    cnt_q;
  logic [1:0]    disp_q, disp_d;
  logic [1:0]    disp_prog_q;
  logic          reject_q;
  logic          ready, accept, pop;
  logic [1:0]    avail;

  assign ready  = (cnt_q != 4'(QDEPTH));
  assign accept = req.req_valid && ready && (req.req_prog != PROG_NONE);

  // a machine with a start already in flight is not a candidate
  assign avail = ~m_busy & ~disp_q;
  assign pop   = (cnt_q != 4'd0) && (|avail);

  always_comb begin
    disp_d = 2'b00;
    unique case (1'b1)
      avail[0]:             disp_d = 2'b01;
      avail[1] & ~avail[0]: disp_d = 2'b10;
      default:              disp_d = 2'b00;
    endcase
    if (!pop) disp_d = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst && accept) mem[wr_ptr] <= req.req_prog;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= 4'd0;
      disp_q      <= 2'b00;
      disp_prog_q <= PROG_NONE;
      reject_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        disp_prog_q <= mem[rd_ptr];
      end
      cnt_q    <= cnt_q + {3'b000, accept} - {3'b000, pop};
      disp_q   <= disp_d;
      reject_q <= req.req_valid && !accept;
    end
  end

  assign req.req_ready = ready;
  assign req.reject    = reject_q;
  assign q_count       = cnt_q;

  for (genvar i = 0; i < 2; i++) begin : g_m
    lav_machine #(
      .T_SEC (T_SEC),
      .T_LAV (T_LAV),
      .T_PES (T_PES)
    ) u_m (
      .clk        (clk),
      .rst        (rst),
      .start      (disp_q[i]),
      .start_prog (disp_prog_q),
`ifdef LAV_SCHED_CANCEL_EN
      .cancel     (cancel[i]),
`endif
      .busy       (m_busy[i]),
      .prog       (m_prog[2*i +: 2]),
      .done       (m_done[i])
    );
  end

endmodule

// File: tb/tb_lav_scheduler.sv
// Directed plus random checks of lav_scheduler against a queue-based model.
// Optional build macro: LAV_SCHED_CANCEL_EN (cancel stimulus enabled).
module tb_lav_scheduler;
  import lav_pkg::*;

  localparam int QD = 4;
  localparam int TS = 3;
  localparam int TL = 4;
  localparam int TP = 9;
`ifdef LAV_SCHED_CANCEL_EN
  localparam logic [1:0] CMASK = 2'b11;
`else
  localparam logic [1:0] CMASK = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [1:0] cancel;
  logic [1:0] m_busy, m_done;
  logic [3:0] m_prog, q_count;

  always #5 clk = ~clk;

  lav_scheduler_if rq ();

  lav_scheduler #(
    .QDEPTH (QD),
    .T_SEC  (TS),
    .T_LAV  (TL),
    .T_PES  (TP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (rq.slave),
`ifdef LAV_SCHED_CANCEL_EN
    .cancel  (cancel),
`endif
    .m_busy  (m_busy),
    .m_prog  (m_prog),
    .m_done  (m_done),
    .q_count (q_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  string tag;

  // reference: job queue plus remaining run cycles per machine
  logic [1:0] mq [$];
  int         left [2];
  logic [1:0] mp   [2];
  logic [1:0] pend [2];
  bit         rej;

  function automatic int dur(logic [1:0] p);
    case (p)
      2'b01:   return TS;
      2'b10:   return TL;
      2'b11:   return TP;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 2; i++) begin
      left[i] = 0;
      mp[i]   = 2'b00;
      pend[i] = 2'b00;
    end
    rej = 1'b0;
  endtask

  task automatic model_edge(bit v, logic [1:0] p, logic [1:0] c);
    int         sz;
    bit         rdy, given;
    logic [1:0] np [2];
    sz    = mq.size();
    rdy   = (sz != QD);
    given = 1'b0;
    np[0] = 2'b00;
    np[1] = 2'b00;
    for (int i = 0; i < 2; i++)
      if (sz > 0 && !given && left[i] == 0 && pend[i] == 2'b00) begin
        np[i] = mq.pop_front();
        given = 1'b1;
      end
    for (int i = 0; i < 2; i++) begin
      if (pend[i] != 2'b00) begin
        left[i] = dur(pend[i]);
        mp[i]   = pend[i];
      end else if (left[i] > 0) begin
        if (c[i] && left[i] > 1) left[i] = 0;
        else left[i] = left[i] - 1;
      end
    end
    pend[0] = np[0];
    pend[1] = np[1];
    if (v && rdy && p != 2'b00) mq.push_back(p);
    rej = v && !(rdy && p != 2'b00);
  endtask

  task automatic chk(string name, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [1:0] eb, ed;
    logic [3:0] ep;
    for (int i = 0; i < 2; i++) begin
      eb[i]       = (left[i] > 0);
      ed[i]       = (left[i] == 1);
      ep[2*i +: 2] = (left[i] > 0) ? mp[i] : 2'b00;
    end
    chk({tag, "_busy"},   8'(m_busy),       8'(eb));
    chk({tag, "_prog"},   8'(m_prog),       8'(ep));
    chk({tag, "_done"},   8'(m_done),       8'(ed));
    chk({tag, "_qcount"}, 8'(q_count),      8'(mq.size()));
    chk({tag, "_ready"},  8'(rq.req_ready), 8'(mq.size() != QD));
    chk({tag, "_reject"}, 8'(rq.reject),    8'(rej));
  endtask

  task automatic step(bit v, logic [1:0] p, logic [1:0] c = 2'b00);
    rq.req_valid = v;
    rq.req_prog  = p;
    cancel       = c;
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(v, p, cancel & CMASK);
    #1;
    check_model();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00);
  endtask

  initial begin
    rst          = 1'b0;
    rq.req_valid = 1'b0;
    rq.req_prog  = 2'b00;
    cancel       = 2'b00;
    model_reset();

    tag = "reset";
    step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    chk("reset_reject", 8'(rq.reject), 8'd0);
    rst = 1'b1;

    tag = "single_lav";
    step(1'b1, 2'b10);
    for (int e = 1; e <= 7; e++) begin
      step(1'b0, 2'b00);
      chk("single_lav_busy0", 8'(m_busy[0]), 8'(e >= 2 && e <= 5));
      chk("single_lav_done0", 8'(m_done[0]), 8'(e == 5));
    end
    chk("single_lav_q", 8'(q_count), 8'd0);

    tag = "three_jobs";
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    for (int e = 3; e <= 16; e++) begin
      step(1'b0, 2'b00);
      chk("three_jobs_busy0", 8'(m_busy[0]), 8'(e <= 10));
      chk("three_jobs_busy1", 8'(m_busy[1]),
          8'((e >= 3 && e <= 5) || (e >= 8 && e <= 11)));
    end

    tag = "overflow";
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    for (int k = 0; k < 5; k++) step(1'b1, 2'b01);
    chk("overflow_reject", 8'(rq.reject),    8'd1);
    chk("overflow_ready",  8'(rq.req_ready), 8'd0);
    chk("overflow_q",      8'(q_count),      8'd4);
    idle(40);

    tag = "illegal";
    step(1'b1, 2'b00);
    chk("illegal_reject", 8'(rq.reject), 8'd1);
    chk("illegal_busy",   8'(m_busy),    8'd0);
    idle(3);

    tag = "mid_reset";
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    idle(2);
    rst = 1'b0;
    step(1'b1, 2'b01);
    chk("mid_reset_busy", 8'(m_busy),  8'd0);
    chk("mid_reset_done", 8'(m_done),  8'd0);
    chk("mid_reset_q",    8'(q_count), 8'd0);
    rst = 1'b1;
    idle(2);

`ifdef LAV_SCHED_CANCEL_EN
    tag = "cancel";
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00, 2'b10);
    chk("cancel_busy1", 8'(m_busy[1]), 8'd0);
    chk("cancel_done1", 8'(m_done[1]), 8'd0);
    idle(20);
`endif

    tag = "random";
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(99) != 0);
      step(($urandom_range(9) < 6), 2'($urandom),
           ($urandom_range(19) == 0) ? 2'($urandom) : 2'b00);
    end
    rst = 1'b1;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
